recovery_response_arbiter: RTL and testbench

//  Shares the recovery transmitter's response header/data interface among NumReq response

---
 rtl/i3c_pkg.sv | 13 +
 rtl/recovery_arb_picker.sv | 50 +++++
 rtl/recovery_response_arbiter.sv | 172 +++++++++++++++++
 tb/tb_recovery_response_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared types for the I3C recovery response arbiter.
package i3c_pkg;

  typedef enum logic [1:0] {
    Idle,
    Hdr,
    Data,
    Drain
  } rec_arb_state_e;

  localparam int unsigned RecLenW = 16;

endpackage

// File: rtl/recovery_arb_picker.sv
// Combinational winner select for the recovery response arbiter.
// I3C_RECOVERY_ARB_RR_EN selects round-robin from start_i; otherwise lowest index wins.
module recovery_arb_picker #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   start_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic found;

  assign any_o = |valid_i;

`ifdef I3C_RECOVERY_ARB_RR_EN
  int unsigned pos;

  // Walk NumReq positions starting at start_i, wrapping; the first valid one wins.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos = 32'(start_i) + i;
      if (pos >= NumReq) pos = pos - NumReq;
      if (!found && valid_i[IdxW'(pos)]) begin
        found = 1'b1;
        idx_o = IdxW'(pos);
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start_i;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && valid_i[IdxW'(i)]) begin
        found = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/recovery_response_arbiter.sv
// Shares the recovery transmitter response header/data stream among NumReq producers.
// I3C_RECOVERY_ARB_RR_EN enables round-robin arbitration (default: fixed priority, index 0 first).
module recovery_response_arbiter
  import i3c_pkg::*;
#(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            soft_reset_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq-1:0][RecLenW-1:0]  req_len_i,
  input  logic [NumReq-1:0]               req_dvalid_i,
  output logic [NumReq-1:0]               req_dready_o,
  input  logic [NumReq-1:0][7:0]          req_data_i,
  input  logic [NumReq-1:0]               req_dlast_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [RecLenW-1:0]              res_len_o,
  output logic                            res_dvalid_o,
  input  logic                            res_dready_i,
  output logic [7:0]                      res_data_o,
  output logic                            res_dlast_o,
  input  logic                            host_abort_i,
  output logic                            busy_o,
  output logic [IdxW-1:0]                 grant_o,
  output logic                            len_err_o
);

  rec_arb_state_e     state_q, state_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    rr_q;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic [RecLenW-1:0] len_q, count_q;
  logic [RecLenW:0]   count_inc;
  logic               len_err_q, len_err_d;
  logic               sel_dvalid, sel_dlast;
  logic               beat, advance, hdr_acc;

  assign sel_dvalid = req_dvalid_i[grant_q];
  assign sel_dlast  = req_dlast_i[grant_q];
  assign count_inc  = {1'b0, count_q} + (RecLenW + 1)'(1);

  recovery_arb_picker #(
    .NumReq (NumReq)
  ) u_picker (
    .valid_i (req_valid_i),
    .start_i (rr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    len_err_d    = 1'b0;
    advance      = 1'b0;
    hdr_acc      = 1'b0;
    beat         = 1'b0;
    req_ready_o  = '0;
    req_dready_o = '0;
    res_valid_o  = 1'b0;
    res_len_o    = '0;
    res_dvalid_o = 1'b0;
    res_data_o   = '0;
    res_dlast_o  = 1'b0;

    case (state_q)
      Idle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = Hdr;
        end
      end
      Hdr: begin
        res_valid_o = 1'b1;
        res_len_o   = req_len_i[grant_q];
        if (host_abort_i) begin
          state_d = Idle;
        end else if (res_ready_i) begin
          req_ready_o[grant_q] = 1'b1;
          hdr_acc              = 1'b1;
          state_d              = Data;
        end
      end
      Data: begin
        res_dvalid_o          = sel_dvalid;
        res_data_o            = req_data_i[grant_q];
        res_dlast_o           = sel_dlast;
        req_dready_o[grant_q] = res_dready_i;
        beat                  = sel_dvalid & res_dready_i;
        // A final beat in the same cycle as an abort completes normally.
        if (beat && sel_dlast) begin
          len_err_d = (count_inc != {1'b0, len_q});
          advance   = 1'b1;
          state_d   = Idle;
        end else if (host_abort_i) begin
          state_d = Drain;
        end
      end
      Drain: begin
        req_dready_o[grant_q] = 1'b1;
        if (sel_dvalid && sel_dlast) begin
          advance = 1'b1;
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    // Soft reset blanks the outputs at once rather than at the next edge.
    if (!soft_reset_ni) begin
      req_ready_o  = '0;
      req_dready_o = '0;
      res_valid_o  = 1'b0;
      res_len_o    = '0;
      res_dvalid_o = 1'b0;
      res_data_o   = '0;
      res_dlast_o  = 1'b0;
    end
  end

  assign busy_o    = soft_reset_ni & (state_q != Idle);
  assign grant_o   = soft_reset_ni ? grant_q : '0;
  assign len_err_o = soft_reset_ni & len_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      grant_q   <= '0;
      len_q     <= '0;
      count_q   <= '0;
      len_err_q <= 1'b0;
    end else if (!soft_reset_ni) begin
      state_q   <= Idle;
      grant_q   <= '0;
      len_q     <= '0;
      count_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      len_err_q <= len_err_d;
      if (hdr_acc) begin
        len_q   <= req_len_i[grant_q];
        count_q <= '0;
      end else if (beat && (count_q != '1)) begin
        count_q <= count_q + RecLenW'(1);
      end
    end
  end

`ifdef I3C_RECOVERY_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (!soft_reset_ni) begin
      rr_q <= '0;
    end else if (advance) begin
      rr_q <= (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);
    end
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign rr_q = '0;
`endif

endmodule

// File: tb/tb_recovery_response_arbiter.sv
// Scoreboard bench for recovery_response_arbiter: producer engine, sink driver, output monitor.
module tb_recovery_response_arbiter;
  localparam int unsigned N = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i, soft_reset_ni;
  logic [N-1:0]         req_valid_i, req_ready_o, req_dvalid_i, req_dready_o, req_dlast_i;
  logic [N-1:0][15:0]   req_len_i;
  logic [N-1:0][7:0]    req_data_i;
  logic                 res_valid_o, res_ready_i, res_dvalid_o, res_dready_i, res_dlast_o;
  logic [15:0]          res_len_o;
  logic [7:0]           res_data_o;
  logic                 host_abort_i, busy_o, len_err_o;
  logic [0:0]           grant_o;

  int passed = 0;
  int total  = 0;

  // producer scripts
  bit p_active[N];
  bit p_hdr[N];
  int p_len[N], p_n[N], p_idx[N], p_base[N], p_rep[N], beats[N];
  bit hs_h[N], hs_d[N];

  // scoreboard queues
  int exp_hdr_g[$];
  int exp_hdr_len[$];
  int exp_d[$];
  int exp_last[$];
  int exp_err[$];

  always #5 clk_i = ~clk_i;

  recovery_response_arbiter #(.NumReq(N)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .soft_reset_ni (soft_reset_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_len_i     (req_len_i),
    .req_dvalid_i  (req_dvalid_i),
    .req_dready_o  (req_dready_o),
    .req_data_i    (req_data_i),
    .req_dlast_i   (req_dlast_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_len_o     (res_len_o),
    .res_dvalid_o  (res_dvalid_o),
    .res_dready_i  (res_dready_i),
    .res_data_o    (res_data_o),
    .res_dlast_o   (res_dlast_o),
    .host_abort_i  (host_abort_i),
    .busy_o        (busy_o),
    .grant_o       (grant_o),
    .len_err_o     (len_err_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk_i);
    #3;
  endtask

  task automatic issue(input int p, input int len, input int n, input int base, input int rep);
    p_len[p] = len; p_n[p] = n; p_base[p] = base; p_rep[p] = rep;
    p_idx[p] = 0; p_hdr[p] = 1'b1; p_active[p] = 1'b1;
  endtask

  task automatic kill_all();
    for (int p = 0; p < N; p++) begin
      p_active[p] = 1'b0; p_hdr[p] = 1'b0; p_rep[p] = 0; p_idx[p] = 0;
    end
  endtask

  // ndata < n means the response is cut short and no len_err check is expected
  task automatic expect_resp(input int g, input int len, input int n, input int base,
                             input int err, input int ndata);
    exp_hdr_g.push_back(g);
    exp_hdr_len.push_back(len);
    for (int i = 0; i < ndata; i++) begin
      exp_d.push_back((base + i) & 8'hFF);
      exp_last.push_back(i == n - 1);
    end
    if (ndata == n) exp_err.push_back(err);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((p_active[0] || p_active[1] || busy_o) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      total++;
      $display("FAIL %s: timeout waiting for idle, got busy expected idle", name);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    busy_o, 0);
    chk({tag, "_grant"},   grant_o, 0);
    chk({tag, "_rvalid"},  res_valid_o, 0);
    chk({tag, "_rdvalid"}, res_dvalid_o, 0);
    chk({tag, "_rdlast"},  res_dlast_o, 0);
    chk({tag, "_rlen"},    res_len_o, 0);
    chk({tag, "_rdata"},   res_data_o, 0);
    chk({tag, "_qready"},  req_ready_o, 0);
    chk({tag, "_qdready"}, req_dready_o, 0);
    chk({tag, "_lenerr"},  len_err_o, 0);
  endtask

  // producer engine: apply last sampled handshakes, drive, then sample just before the edge
  initial begin
    for (int p = 0; p < N; p++) begin
      p_active[p] = 0; p_hdr[p] = 0; p_len[p] = 0; p_n[p] = 0; p_idx[p] = 0;
      p_base[p] = 0; p_rep[p] = 0; beats[p] = 0; hs_h[p] = 0; hs_d[p] = 0;
    end
    req_valid_i = '0; req_dvalid_i = '0; req_dlast_i = '0; req_len_i = '0; req_data_i = '0;
    forever begin
      @(negedge clk_i);
      for (int p = 0; p < N; p++) begin
        if (hs_h[p]) p_hdr[p] = 1'b0;
        if (hs_d[p]) begin
          beats[p]++;
          if (p_idx[p] == p_n[p] - 1) begin
            if (p_rep[p] > 0) begin
              p_rep[p]--; p_hdr[p] = 1'b1; p_idx[p] = 0;
            end else begin
              p_active[p] = 1'b0;
            end
          end else begin
            p_idx[p]++;
          end
        end
        req_valid_i[p]  = p_active[p] && p_hdr[p];
        req_len_i[p]    = 16'(p_len[p]);
        req_dvalid_i[p] = p_active[p] && !p_hdr[p];
        req_data_i[p]   = 8'(p_base[p] + p_idx[p]);
        req_dlast_i[p]  = req_dvalid_i[p] && (p_idx[p] == p_n[p] - 1);
      end
      #4;
      for (int p = 0; p < N; p++) begin
        hs_h[p] = req_valid_i[p] && req_ready_o[p];
        hs_d[p] = req_dvalid_i[p] && req_dready_o[p];
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT hands something to the transmitter
  initial begin
    bit pend;
    int pe;
    pend = 0;
    pe   = 0;
    forever begin
      @(negedge clk_i);
      #4;
      if (pend) begin
        chk("len_err", len_err_o, pe);
        pend = 0;
      end else if (len_err_o) begin
        total++;
        $display("FAIL len_err_spurious: got 1 expected 0");
      end
      if (res_valid_o && res_ready_i) begin
        if (exp_hdr_g.size() == 0) begin
          total++;
          $display("FAIL hdr_unexpected: got header len %0d expected none", res_len_o);
        end else begin
          chk("hdr_grant", grant_o, exp_hdr_g.pop_front());
          chk("hdr_len", res_len_o, exp_hdr_len.pop_front());
        end
      end
      if (res_dvalid_o && res_dready_i) begin
        if (exp_d.size() == 0) begin
          total++;
          $display("FAIL data_unexpected: got byte %0d expected none", res_data_o);
        end else begin
          chk("data", res_data_o, exp_d.pop_front());
          chk("dlast", res_dlast_o, exp_last.pop_front());
          if (res_dlast_o) begin
            pend = 1;
            pe   = (exp_err.size() > 0) ? exp_err.pop_front() : 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, g2, g3;
    rst_i = 1'b1; soft_reset_ni = 1'b1;
    res_ready_i = 1'b0; res_dready_i = 1'b0; host_abort_i = 1'b0;
    step(); step();
    chk_zero("in_reset");
    rst_i = 1'b0;
    step();
    chk_zero("after_reset");

    // 1: single response, sink always ready
    res_ready_i = 1'b1; res_dready_i = 1'b1;
    expect_resp(0, 4, 4, 8'hA0, 0, 4);
    issue(0, 4, 4, 8'hA0, 0);
    step();
    chk("t1_latency_rvalid", res_valid_o, 0);
    step();
    chk("t1_hdr_rvalid", res_valid_o, 1);
    wait_done("t1");
    chk("t1_busy_after", busy_o, 0);

    // 2: contention; clear the rr pointer first
    soft_reset_ni = 1'b0; step(); soft_reset_ni = 1'b1; step();
`ifdef I3C_RECOVERY_ARB_RR_EN
    g0 = 0; g1 = 1; g2 = 0; g3 = 1;
`else
    g0 = 0; g1 = 0; g2 = 1; g3 = 1;
`endif
    expect_resp(g0, g0 ? 3 : 2, g0 ? 3 : 2, g0 ? 8'h20 : 8'h10, 0, g0 ? 3 : 2);
    expect_resp(g1, g1 ? 3 : 2, g1 ? 3 : 2, g1 ? 8'h20 : 8'h10, 0, g1 ? 3 : 2);
    expect_resp(g2, g2 ? 3 : 2, g2 ? 3 : 2, g2 ? 8'h20 : 8'h10, 0, g2 ? 3 : 2);
    expect_resp(g3, g3 ? 3 : 2, g3 ? 3 : 2, g3 ? 8'h20 : 8'h10, 0, g3 ? 3 : 2);
    issue(0, 2, 2, 8'h10, 1);
    issue(1, 3, 3, 8'h20, 1);
    wait_done("t2");

    // 3: short response flagged once, next one clean
    expect_resp(1, 3, 2, 8'h30, 1, 2);
    issue(1, 3, 2, 8'h30, 0);
    wait_done("t3a");
    expect_resp(1, 2, 2, 8'h40, 0, 2);
    issue(1, 2, 2, 8'h40, 0);
    wait_done("t3b");

    // 4: abort after the first byte; remaining bytes drained locally
    beats[0] = 0;
    expect_resp(0, 5, 5, 8'h50, 0, 1);
    issue(0, 5, 5, 8'h50, 0);
    for (int k = 0; k < 50 && beats[0] < 1; k++) step();
    host_abort_i = 1'b1; res_dready_i = 1'b0;
    step();
    host_abort_i = 1'b0;
    chk("t4_drain_busy", busy_o, 1);
    chk("t4_drain_rdvalid", res_dvalid_o, 0);
    chk("t4_drain_dready", req_dready_o, 1);
    wait_done("t4");
    chk("t4_beats", beats[0], 5);
    chk("t4_busy_after", busy_o, 0);
    res_dready_i = 1'b1;

    // 5: header back-pressure
    res_ready_i = 1'b0;
    expect_resp(0, 7, 7, 8'h60, 0, 7);
    issue(0, 7, 7, 8'h60, 0);
    step(); step();
    for (int k = 0; k < 10; k++) begin
      chk("t5_rvalid_held", res_valid_o, 1);
      chk("t5_rlen_stable", res_len_o, 7);
      chk("t5_qready_low", req_ready_o, 0);
      step();
    end
    res_ready_i = 1'b1;
    wait_done("t5");

    // 6a: hard reset mid-data
    res_dready_i = 1'b0;
    expect_resp(1, 3, 3, 8'h70, 0, 0);
    issue(1, 3, 3, 8'h70, 0);
    for (int k = 0; k < 50 && !res_dvalid_o; k++) step();
    chk("t6a_in_data", res_dvalid_o, 1);
    rst_i = 1'b1;
    #1;
    chk_zero("t6a_rst");
    kill_all();
    step();
    rst_i = 1'b0;
    res_dready_i = 1'b1;
    step();
    expect_resp(0, 1, 1, 8'h80, 0, 1);
    expect_resp(1, 1, 1, 8'h90, 0, 1);
    issue(0, 1, 1, 8'h80, 0);
    issue(1, 1, 1, 8'h90, 0);
    wait_done("t6a_after");

    // 6b: soft reset mid-drain, with pointer pushed to 1 beforehand
    expect_resp(0, 1, 1, 8'hB0, 0, 1);
    issue(0, 1, 1, 8'hB0, 0);
    wait_done("t6b_pre");
    res_dready_i = 1'b0;
    expect_resp(1, 4, 4, 8'hC0, 0, 0);
    issue(1, 4, 4, 8'hC0, 0);
    for (int k = 0; k < 50 && !res_dvalid_o; k++) step();
    host_abort_i = 1'b1;
    step();
    host_abort_i = 1'b0;
    chk("t6b_in_drain", busy_o, 1);
    soft_reset_ni = 1'b0;
    #1;
    chk_zero("t6b_soft");
    kill_all();
    step();
    soft_reset_ni = 1'b1;
    res_dready_i = 1'b1;
    step();
    expect_resp(0, 2, 2, 8'hD0, 0, 2);
    expect_resp(1, 2, 2, 8'hE0, 0, 2);
    issue(0, 2, 2, 8'hD0, 0);
    issue(1, 2, 2, 8'hE0, 0);
    wait_done("t6b_after");
    step(); step();

    chk("hdr_queue_empty", exp_hdr_g.size(), 0);
    chk("data_queue_empty", exp_d.size(), 0);
    chk("err_queue_empty", exp_err.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
